// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master
//  Purpose  : SPI mode-0 initiator issuing 16-bit {rw,addr,data} register frames.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_master #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_IDLE  = 4
) (
    input  logic       sys_clk_25m,
    input  logic       sys_rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       spi_clk,
    output logic       spi_cs_n,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // SETUP and HOLD each carry one extra CS-low cycle; GAP is one short because
    // the IDLE cycle following done completes the CS_IDLE high time.
    localparam logic [7:0] C_DIV_LOAD   = 8'(CLK_DIV - 1);
    localparam logic [7:0] C_SETUP_LOAD = 8'(CS_SETUP);
    localparam logic [7:0] C_HOLD_LOAD  = 8'(CS_HOLD);
    localparam logic [7:0] C_GAP_LOAD   = 8'(CS_IDLE - 2);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [3:0]  bit_q;
    logic [15:0] shreg_q;
    logic        rd_op_q;
    logic [1:0]  miso_sync_q;
    logic        busy_q;
    logic        done_q;
    logic [7:0]  rd_data_q;
    logic        sck_q;
    logic        cs_n_q;
    logic        mosi_q;

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_data  = rd_data_q;
    assign spi_clk  = sck_q;
    assign spi_cs_n = cs_n_q;
    assign spi_mosi = mosi_q;

    always_ff @(posedge sys_clk_25m) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'h00;
            bit_q       <= 4'h0;
            shreg_q     <= 16'h0000;
            rd_op_q     <= 1'b0;
            miso_sync_q <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_data_q   <= 8'h00;
            sck_q       <= 1'b0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
        end else begin
            miso_sync_q <= {miso_sync_q[0], spi_miso};
            done_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        shreg_q <= {rw, addr, (rw ? 8'h00 : wr_data)};
                        rd_op_q <= rw;
                        mosi_q  <= rw;
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= C_SETUP_LOAD;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == 8'h00) begin
                        mosi_q  <= shreg_q[15];
                        bit_q   <= 4'h0;
                        cnt_q   <= C_DIV_LOAD;
                        state_q <= ST_SHIFT;
                    end else begin
                        cnt_q <= cnt_q - 8'h01;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q != 8'h00) begin
                        cnt_q <= cnt_q - 8'h01;
                    end else if (!sck_q) begin
                        sck_q <= 1'b1;
                        cnt_q <= C_DIV_LOAD;
                    end else begin
                        // End of high phase: capture MISO and present the next bit.
                        sck_q   <= 1'b0;
                        shreg_q <= {shreg_q[14:0], miso_sync_q[1]};
                        bit_q   <= bit_q + 4'h1;
                        if (bit_q == 4'hF) begin
                            cnt_q   <= C_HOLD_LOAD;
                            state_q <= ST_HOLD;
                        end else begin
                            mosi_q <= shreg_q[14];
                            cnt_q  <= C_DIV_LOAD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == 8'h00) begin
                        cs_n_q  <= 1'b1;
                        mosi_q  <= 1'b0;
                        cnt_q   <= C_GAP_LOAD;
                        state_q <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q - 8'h01;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == 8'h00) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                        if (rd_op_q) begin
                            rd_data_q <= shreg_q[7:0];
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'h01;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master
//  Purpose  : Self-checking bench for spi_master with a behavioural SPI slave.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_IDLE  = 4;
    localparam int LAT      = CS_SETUP + 32 * CLK_DIV + CS_HOLD + CS_IDLE + 1;
    localparam int CS_LOW   = LAT + 1 - CS_IDLE;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       spi_clk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_rd;

    // Per-frame observations gathered by run_frame
    logic [15:0] r_mosi;
    int r_rises, r_cs_low, r_cs_high, r_cs_rise, r_done_s, r_done_cnt;
    int r_busy_bad, r_glitch, r_unstable;

    always #5 clk = ~clk;

    spi_master #(
        .CLK_DIV (CLK_DIV),
        .CS_SETUP(CS_SETUP),
        .CS_HOLD (CS_HOLD),
        .CS_IDLE (CS_IDLE)
    ) dut (
        .sys_clk_25m(clk),
        .sys_rst    (rst),
        .start      (start),
        .rw         (rw),
        .addr       (addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .rd_data    (rd_data),
        .spi_clk    (spi_clk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    // Issues one frame starting at the current negedge and watches it as a mode-0
    // slave until done; sample s reflects the state after edge E0+s.
    task automatic run_frame(input logic f_rw, input logic [6:0] f_addr, input logic [7:0] f_wd,
                             input logic [7:0] s_byte, input bit hold, input bit pulses);
        logic [15:0] sw;
        logic psck, pcs, pmosi;
        int falls;
        bit seen_low;
        sw = {8'($urandom), s_byte};
        start = 1'b1; rw = f_rw; addr = f_addr; wr_data = f_wd;
        r_mosi = 16'h0; r_rises = 0; r_cs_low = 0; r_cs_high = 0; r_cs_rise = 0;
        r_done_s = -1; r_done_cnt = 0; r_busy_bad = 0; r_glitch = 0; r_unstable = 0;
        psck = spi_clk; pcs = spi_cs_n; pmosi = spi_mosi; falls = 0; seen_low = 0;
        spi_miso = sw[15];
        for (int s = 0; s < 400; s++) begin
            @(negedge clk);
            if (s == 0) begin
                start = hold;
                if (!busy) r_busy_bad++;
            end
            if (pulses && (s == 10 || s == 50)) begin
                start = 1'b1; rw = ~f_rw; addr = 7'($urandom); wr_data = 8'($urandom);
            end else if (pulses && (s == 11 || s == 51)) begin
                start = 1'b0;
            end
            if (!spi_cs_n) begin
                r_cs_low++; seen_low = 1;
            end else if (seen_low) begin
                r_cs_high++;
            end
            if (spi_cs_n && !pcs) r_cs_rise++;
            if (spi_clk && !psck) begin
                r_rises++;
                r_mosi = {r_mosi[14:0], spi_mosi};
            end
            if (spi_clk && spi_cs_n) r_glitch++;
            if (spi_clk && psck && spi_mosi !== pmosi) r_unstable++;
            if (!spi_clk && psck) falls++;
            if (done) begin
                r_done_cnt++;
                if (r_done_s < 0) r_done_s = s;
                if (busy) r_busy_bad++;
            end else if (s > 0 && !busy) begin
                r_busy_bad++;
            end
            spi_miso = (falls < 16) ? sw[15 - falls] : 1'b0;
            psck = spi_clk; pcs = spi_cs_n; pmosi = spi_mosi;
            if (done) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rw = 1'b0; addr = 7'h0; wr_data = 8'h0; spi_miso = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, rd_data, spi_clk, spi_cs_n, spi_mosi} !== {2'b00, 8'h00, 3'b010}) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b rd=%h sck=%b cs_n=%b mosi=%b, want 0 0 00 0 1 0",
                     busy, done, rd_data, spi_clk, spi_cs_n, spi_mosi);
        end
        rst = 1'b0;
        exp_rd = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_write();
        run_frame(1'b0, 7'h12, 8'hA5, 8'($urandom), 1'b0, 1'b0);
        checks++; if (r_mosi !== 16'h12A5) begin failures++; $display("FAIL write_mosi: got %h want 12a5", r_mosi); end
        checks++; if (r_rises !== 16) begin failures++; $display("FAIL write_sck_rises: got %0d want 16", r_rises); end
        checks++; if (r_cs_low !== CS_LOW) begin failures++; $display("FAIL write_cs_low: got %0d want %0d", r_cs_low, CS_LOW); end
        checks++; if (r_done_s !== LAT) begin failures++; $display("FAIL write_latency: got %0d want %0d", r_done_s, LAT); end
        checks++; if (rd_data !== exp_rd) begin failures++; $display("FAIL write_rd_data: got %h want %h", rd_data, exp_rd); end
        checks++; if (r_glitch + r_unstable + r_busy_bad !== 0) begin
            failures++; $display("FAIL write_protocol: glitch=%0d unstable=%0d busy_bad=%0d want 0", r_glitch, r_unstable, r_busy_bad);
        end
    endtask

    task automatic test_read();
        run_frame(1'b1, 7'h05, 8'hFF, 8'h3C, 1'b0, 1'b0);
        exp_rd = 8'h3C;
        checks++; if (r_mosi !== 16'h8500) begin failures++; $display("FAIL read_mosi: got %h want 8500", r_mosi); end
        checks++; if (rd_data !== exp_rd) begin failures++; $display("FAIL read_rd_data: got %h want %h", rd_data, exp_rd); end
        checks++; if (r_busy_bad !== 0) begin failures++; $display("FAIL read_busy: bad samples %0d want 0", r_busy_bad); end
        checks++; if (r_done_s !== LAT) begin failures++; $display("FAIL read_latency: got %0d want %0d", r_done_s, LAT); end
    endtask

    task automatic test_ignore_start();
        logic [6:0] a;
        logic [7:0] d;
        int extra_low, extra_done;
        a = 7'($urandom); d = 8'($urandom);
        run_frame(1'b0, a, d, 8'($urandom), 1'b0, 1'b1);
        checks++; if (r_mosi !== {1'b0, a, d}) begin failures++; $display("FAIL ignore_mosi: got %h want %h", r_mosi, {1'b0, a, d}); end
        checks++; if (r_done_cnt !== 1 || r_done_s !== LAT) begin
            failures++; $display("FAIL ignore_done: got count=%0d at %0d want 1 at %0d", r_done_cnt, r_done_s, LAT);
        end
        extra_low = 0; extra_done = 0;
        repeat (200) begin
            @(negedge clk);
            if (!spi_cs_n) extra_low++;
            if (done) extra_done++;
        end
        checks++; if (extra_low + extra_done !== 0) begin
            failures++; $display("FAIL ignore_extra_frame: cs_low=%0d done=%0d want 0 0", extra_low, extra_done);
        end
    endtask

    task automatic test_reset_mid();
        int rises, extra_low, extra_done;
        logic psck;
        logic [6:0] a;
        start = 1'b1; rw = 1'b0; addr = 7'($urandom); wr_data = 8'($urandom);
        rises = 0; psck = spi_clk;
        for (int s = 0; s < 300 && rises < 8; s++) begin
            @(negedge clk);
            start = 1'b0;
            if (spi_clk && !psck) rises++;
            psck = spi_clk;
        end
        checks++; if (rises !== 8) begin failures++; $display("FAIL midreset_reach_bit7: got %0d rises want 8", rises); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({spi_cs_n, spi_clk, busy, done} !== 4'b1000) begin
            failures++; $display("FAIL midreset_outputs: got cs_n=%b sck=%b busy=%b done=%b want 1 0 0 0",
                                 spi_cs_n, spi_clk, busy, done);
        end
        rst = 1'b0;
        exp_rd = 8'h00;
        extra_low = 0; extra_done = 0;
        repeat (200) begin
            @(negedge clk);
            if (!spi_cs_n) extra_low++;
            if (done) extra_done++;
        end
        checks++; if (extra_low + extra_done !== 0) begin
            failures++; $display("FAIL midreset_no_done: cs_low=%0d done=%0d want 0 0", extra_low, extra_done);
        end
        a = 7'($urandom);
        run_frame(1'b1, a, 8'($urandom), 8'hC3, 1'b0, 1'b0);
        exp_rd = 8'hC3;
        checks++; if (r_mosi !== {1'b1, a, 8'h00} || r_done_s !== LAT || rd_data !== exp_rd) begin
            failures++; $display("FAIL midreset_recover: got mosi=%h lat=%0d rd=%h want %h %0d %h",
                                 r_mosi, r_done_s, rd_data, {1'b1, a, 8'h00}, LAT, exp_rd);
        end
    endtask

    task automatic test_back_to_back();
        logic       f_rw;
        logic [6:0] a;
        logic [7:0] d, sb;
        for (int i = 0; i < 3; i++) begin
            f_rw = 1'($urandom); a = 7'($urandom); d = 8'($urandom); sb = 8'($urandom);
            run_frame(f_rw, a, d, sb, (i < 2), 1'b0);
            if (f_rw) exp_rd = sb;
            checks++; if (r_mosi !== {f_rw, a, (f_rw ? 8'h00 : d)}) begin
                failures++; $display("FAIL b2b_mosi[%0d]: got %h want %h", i, r_mosi, {f_rw, a, (f_rw ? 8'h00 : d)});
            end
            checks++; if (r_cs_low !== CS_LOW || r_cs_high !== CS_IDLE || r_done_s !== LAT || r_busy_bad !== 0) begin
                failures++; $display("FAIL b2b_timing[%0d]: got cs_low=%0d cs_high=%0d lat=%0d busy_bad=%0d want %0d %0d %0d 0",
                                     i, r_cs_low, r_cs_high, r_done_s, r_busy_bad, CS_LOW, CS_IDLE, LAT);
            end
            checks++; if (rd_data !== exp_rd) begin failures++; $display("FAIL b2b_rd_data[%0d]: got %h want %h", i, rd_data, exp_rd); end
        end
        @(negedge clk);
        checks++; if (spi_cs_n !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL b2b_stop: got cs_n=%b busy=%b want 1 0", spi_cs_n, busy);
        end
    endtask

    task automatic test_loopback();
        run_frame(1'b0, 7'h33, 8'h5A, 8'($urandom), 1'b0, 1'b0);
        checks++; if (r_mosi[14:8] !== 7'h33 || r_mosi[15] !== 1'b0) begin
            failures++; $display("FAIL loop_cmd: got addr=%h rw=%b want 33 0", r_mosi[14:8], r_mosi[15]);
        end
        checks++; if (r_mosi[7:0] !== 8'h5A) begin failures++; $display("FAIL loop_data: got %h want 5a", r_mosi[7:0]); end
        checks++; if (r_cs_rise !== 1) begin failures++; $display("FAIL loop_sel_end: got %0d want 1", r_cs_rise); end
    endtask

    task automatic test_random();
        logic       f_rw;
        logic [6:0] a;
        logic [7:0] d, sb;
        for (int i = 0; i < 8; i++) begin
            f_rw = 1'($urandom); a = 7'($urandom); d = 8'($urandom); sb = 8'($urandom);
            run_frame(f_rw, a, d, sb, 1'b0, 1'b0);
            if (f_rw) exp_rd = sb;
            checks++;
            if (r_mosi !== {f_rw, a, (f_rw ? 8'h00 : d)} || rd_data !== exp_rd || r_done_s !== LAT || r_rises !== 16) begin
                failures++; $display("FAIL random[%0d]: got mosi=%h rd=%h lat=%0d rises=%0d want %h %h %0d 16",
                                     i, r_mosi, rd_data, r_done_s, r_rises, {f_rw, a, (f_rw ? 8'h00 : d)}, exp_rd, LAT);
            end
            repeat (1 + ($urandom % 5)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_loopback();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
